// File: rtl/reg_file_if.sv
// Register file bundle: write-back triple, two read ports and the issue/flush
// scoreboard controls seen by decode.
interface reg_file_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);

  logic [ADDR_WIDTH-1:0] reg_write_addr;
  logic [DATA_WIDTH-1:0] reg_write_data;
  logic                  reg_write_enable;

  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;

  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic                  flush;
  logic                  hazard_stall;

  // Pipeline side: drives write-back, read indices and issue controls.
  modport master (
    output reg_write_addr, reg_write_data, reg_write_enable,
    output rs1_addr, rs2_addr,
    output issue_valid, issue_rd, flush,
    input  rs1_data, rs2_data, hazard_stall
  );

  // Register file side.
  modport slave (
    input  reg_write_addr, reg_write_data, reg_write_enable,
    input  rs1_addr, rs2_addr,
    input  issue_valid, issue_rd, flush,
    output rs1_data, rs2_data, hazard_stall
  );

endinterface

// File: rtl/reg_file.sv
// Architectural register file: x0 hardwired to zero, write-back bypass onto
// both combinational read ports, and a one-writer-per-register busy
// scoreboard that raises a decode stall on in-flight sources.
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic       clk,
  input  logic       reset,
  reg_file_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;
  logic [DEPTH-1:0]      busy_eff;
  logic [DEPTH-1:0]      wb_hit;
  logic [DEPTH-1:0]      issue_hit;
  logic                  wr_commit;

  // One-hot decode of the write-back and issue destinations (index 0 never hits).
  always_comb begin
    wb_hit    = '0;
    issue_hit = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      wb_hit[i]    = bus.reg_write_enable && (bus.reg_write_addr == ADDR_WIDTH'(i));
      issue_hit[i] = bus.issue_valid && (bus.issue_rd == ADDR_WIDTH'(i));
    end
  end

  assign wr_commit = bus.reg_write_enable && (bus.reg_write_addr != '0);

  // Register storage; writes to x0 are dropped so regs[0] stays at its reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[bus.reg_write_addr] <= bus.reg_write_data;
    end
  end

  // Read port 1: x0 reads zero, a same-cycle write-back is bypassed.
  always_comb begin
    bus.rs1_data = regs[bus.rs1_addr];
    if (bus.rs1_addr == '0) begin
      bus.rs1_data = '0;
    end else if (wb_hit[bus.rs1_addr]) begin
      bus.rs1_data = bus.reg_write_data;
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    bus.rs2_data = regs[bus.rs2_addr];
    if (bus.rs2_addr == '0) begin
      bus.rs2_data = '0;
    end else if (wb_hit[bus.rs2_addr]) begin
      bus.rs2_data = bus.reg_write_data;
    end
  end

  // Scoreboard next state: flush beats issue, issue beats write-back clear.
  always_comb begin
    busy_next = busy;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (bus.flush) begin
        busy_next[i] = 1'b0;
      end else if (issue_hit[i]) begin
        busy_next[i] = 1'b1;
      end else if (wb_hit[i]) begin
        busy_next[i] = 1'b0;
      end
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // A write-back landing this cycle resolves its hazard through the bypass.
  assign busy_eff = busy & ~wb_hit;

  // Stall when either non-zero source still has an outstanding writer.
  always_comb begin
    bus.hazard_stall = 1'b0;
    if ((bus.rs1_addr != '0) && busy_eff[bus.rs1_addr]) begin
      bus.hazard_stall = 1'b1;
    end
    if ((bus.rs2_addr != '0) && busy_eff[bus.rs2_addr]) begin
      bus.hazard_stall = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Randomised and directed bench for reg_file. Stimulus pushes the expected
// read/stall values into a queue; a monitor pops and compares each cycle.
module tb_reg_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk;
  logic reset;

  reg_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int          id;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          total = 0;
  int          bad   = 0;
  int          step_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference read: zero register, bypass, then stored value.
  function automatic logic [31:0] m_read(input logic [4:0] a, input bit we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit m_stall(input logic [4:0] a1, input logic [4:0] a2,
                                 input bit we, input logic [4:0] wa);
    bit s1, s2;
    s1 = (a1 != 5'd0) && m_busy[a1] && !(we && wa == a1);
    s2 = (a2 != 5'd0) && m_busy[a2] && !(we && wa == a2);
    return s1 || s2;
  endfunction

  // One cycle: apply inputs, predict outputs, then advance the model at the edge.
  task automatic step(input bit rst_i, input bit we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1,
                      input logic [4:0] a2, input bit iv, input logic [4:0] ird,
                      input bit fl);
    exp_t e;
    reset                = rst_i;
    bus.reg_write_enable = we;
    bus.reg_write_addr   = wa;
    bus.reg_write_data   = wd;
    bus.rs1_addr         = a1;
    bus.rs2_addr         = a2;
    bus.issue_valid      = iv;
    bus.issue_rd         = ird;
    bus.flush            = fl;
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
    end
    e.id    = step_id;
    e.rs1   = m_read(a1, we, wa, wd);
    e.rs2   = m_read(a2, we, wa, wd);
    e.stall = m_stall(a1, a2, we, wa);
    exp_q.push_back(e);
    step_id++;
    @(posedge clk);
    if (!rst_i) begin
      for (int i = 1; i < 32; i++) begin
        if (fl) m_busy[i] = 1'b0;
        else if (iv && ird == 5'(i)) m_busy[i] = 1'b1;
        else if (we && wa == 5'(i)) m_busy[i] = 1'b0;
      end
      if (we && wa != 5'd0) m_regs[wa] = wd;
    end
    #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    step(1'b0, 1'b0, 5'd0, 32'd0, a1, a2, 1'b0, 5'd0, 1'b0);
  endtask

  // Monitor: compare the combinational outputs mid-cycle against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (bus.rs1_data !== e.rs1) begin
        bad++;
        $display("FAIL rs1_data step=%0d got=%h want=%h", e.id, bus.rs1_data, e.rs1);
      end
      total++;
      if (bus.rs2_data !== e.rs2) begin
        bad++;
        $display("FAIL rs2_data step=%0d got=%h want=%h", e.id, bus.rs2_data, e.rs2);
      end
      total++;
      if (bus.hazard_stall !== e.stall) begin
        bad++;
        $display("FAIL hazard_stall step=%0d got=%b want=%b", e.id, bus.hazard_stall, e.stall);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  a1, a2, wa, ird;
    logic [31:0] wd;
    bit          we, iv, fl, rs;

    reset                = 1'b1;
    bus.reg_write_enable = 1'b0;
    bus.reg_write_addr   = '0;
    bus.reg_write_data   = '0;
    bus.rs1_addr         = '0;
    bus.rs2_addr         = '0;
    bus.issue_valid      = 1'b0;
    bus.issue_rd         = '0;
    bus.flush            = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 1'b0, 5'd0, 1'b0);

    // Write x5, bypass then storage; x6 stays zero.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0);
    rd(5'd5, 5'd6);

    // x0 writes dropped; issue to x0 never stalls.
    step(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    rd(5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    rd(5'd0, 5'd0);

    // Issue x7, stall until its write-back, which clears it combinationally.
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0);
    rd(5'd0, 5'd7);
    rd(5'd0, 5'd7);
    step(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0);
    rd(5'd7, 5'd7);

    // Same-cycle issue and write-back to x9: set wins.
    step(1'b0, 1'b1, 5'd9, 32'h00000909, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
    rd(5'd9, 5'd0);
    step(1'b0, 1'b1, 5'd9, 32'h00009999, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);

    // Flush clears x3/x4; flush beats a same-cycle issue.
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0);
    rd(5'd3, 5'd4);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    rd(5'd3, 5'd4);
    step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1);
    rd(5'd3, 5'd0);

    // Populate x1..x31, busy a few, then async reset between edges.
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(i - 1),
           (i % 7) == 0, 5'((i + 3) % 32), 1'b0);
    end
    rd(5'd31, 5'd17);
    step(1'b1, 1'b0, 5'd0, 32'd0, 5'd31, 5'd17, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd10, 1'b1, 5'd10, 1'b0);
    rd(5'd12, 5'd10);
    rd(5'd1, 5'd2);

    // Random traffic; issue only when the model says decode is not stalled.
    for (int n = 0; n < 400; n++) begin
      a1  = 5'($urandom_range(0, 31));
      a2  = 5'($urandom_range(0, 31));
      we  = ($urandom_range(0, 99) < 40);
      wa  = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      wd  = $urandom;
      ird = 5'($urandom_range(0, 31));
      fl  = ($urandom_range(0, 99) < 4);
      rs  = ($urandom_range(0, 199) == 0);
      iv  = ($urandom_range(0, 99) < 35) && !m_stall(a1, a2, we, wa);
      step(rs, we, wa, wd, a1, a2, iv, ird, fl);
    end
    rd(5'd0, 5'd0);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file at the consuming end of the write-back interface. It accepts the registered write-back triple (`reg_write_addr`, `reg_write_data`, `reg_write_enable`) and serves two combinational read ports to decode. Same-cycle writes are bypassed to the read ports. A per-register busy scoreboard raises a decode stall while a source register has an in-flight write.

## Interface
- `DATA_WIDTH`, 32: register width.
- `ADDR_WIDTH`, 5: register index width; depth = 2^ADDR_WIDTH (32).
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-high; clears all registers and the scoreboard.
- `reg_write_addr` input ADDR_WIDTH: write-back destination index.
- `reg_write_data` input DATA_WIDTH: write-back data.
- `reg_write_enable` input 1: write-back valid.
- `rs1_addr` input ADDR_WIDTH: read port 1 index.
- `rs2_addr` input ADDR_WIDTH: read port 2 index.
- `rs1_data` output DATA_WIDTH: read port 1 data, combinational.
- `rs2_data` output DATA_WIDTH: read port 2 data, combinational.
- `issue_valid` input 1: decode issues an instruction that will write `issue_rd`.
- `issue_rd` input ADDR_WIDTH: destination of the issuing instruction.
- `flush` input 1: pipeline flush; clears all busy bits.
- `hazard_stall` output 1: combinational; a source register is busy.

## Operation
- Storage: 32 x DATA_WIDTH flops, `regs[0]` hardwired to 0. Writes to index 0 are dropped.
- Write: on posedge, if `reg_write_enable` and `reg_write_addr != 0`, set `regs[reg_write_addr] <= reg_write_data`.
- Read, per port X:
  - `rsX_addr == 0` gives 0.
  - Otherwise, if `reg_write_enable` and `reg_write_addr == rsX_addr`, give `reg_write_data` (bypass).
  - Otherwise, give `regs[rsX_addr]`.
- Scoreboard: 32-bit `busy` vector, `busy[0]` is always 0. Next-state per index i != 0, in priority order:
  - `flush` clears `busy[i]`, overriding everything, including a same-cycle issue.
  - `issue_valid && issue_rd == i` sets it (set wins over a same-cycle clear, because a newer write is now outstanding).
  - `reg_write_enable && reg_write_addr == i` clears it.
  - Otherwise `busy[i]` holds.
- Scoreboard counts one outstanding writer per register. A second issue to a busy rd keeps the bit set. The first write-back to that rd clears the bit; handling back-to-back writers is decode's responsibility.
- `hazard_stall` = `(busy_eff[rs1_addr] && rs1_addr != 0) || (busy_eff[rs2_addr] && rs2_addr != 0)`.
  - `busy_eff[i]` = `busy[i] && !(reg_write_enable && reg_write_addr == i)`: a same-cycle write-back resolves the hazard via bypass.
  - `issue_valid` in the current cycle does not affect the current cycle's stall.
- Decode must hold `issue_valid` low while `hazard_stall` is high. The block does not gate it.

## Timing
- Reset values: all `regs` = 0 and `busy` = 0. Hence `rs1_data` = `rs2_data` = 0 and `hazard_stall` = 0 while reset is asserted, unless a bypassed write-back is present on the inputs.
- Reset asserted mid-operation takes effect immediately, with no clock needed. A write present during reset is discarded.
- Write latency: data is visible via bypass in the same cycle, and from storage starting the cycle after the posedge.
- Busy set: visible one cycle after the `issue_valid` posedge.
- Busy clear: takes effect combinationally in the write-back cycle and is stored at its posedge.
- No handshakes on the write-back side; every enabled write is accepted in its cycle.

## Test plan
- Reset, then write `x5 = 0xDEADBEEF` in cycle 1 -> `rs1_addr=5` reads `0xDEADBEEF` in cycle 1 (bypass) and in cycle 2 (storage). `rs2_addr=6` reads 0.
- Write `x0 = 0x12345678`, then read `rs1_addr=0` -> 0 in both the same and the next cycle. `issue_valid` with `issue_rd=0` followed by `rs1_addr=0` -> `hazard_stall=0`.
- Issue `rd=7` at cycle 1; `rs2_addr=7` from cycle 2 -> `hazard_stall=1`. Write-back `x7 = 0xA5A5A5A5` at cycle 4 -> `hazard_stall=0` and `rs2_data=0xA5A5A5A5` in cycle 4; the bit stays clear in cycle 5.
- Same cycle: `issue_valid`, `issue_rd=9`, write-back to x9 -> busy[9]=1 next cycle, so reading x9 stalls.
- Set busy on x3 and x4, then pulse `flush` -> both clear next cycle and `hazard_stall=0`. Also test `flush` together with `issue_rd=3` -> busy[3]=0.
- Populate x1..x31 with `i*0x01010101`, assert `reset` asynchronously between edges -> all reads return 0 immediately and `hazard_stall=0`.
